cmos_stream_tx: RTL and testbench

- Synthesizable CMOS-style video transmitter: takes pixels from an upstream valid/ready source and emits a frame-timed stream (vsync/href/clken/data) with programmable blanking.
- Source end of the per_frame_vsync/href/clken interface consumed by VIP_RGB888_YCbCr444 and the downstream gaussian/canny chain.
- Replaces the behavioural camera model on hardware (e.g. frame buffer readout into the edge pipeline).

---
 rtl/cmos_stream_tx.sv | 140 ++++++++++++++
 tb/tb_cmos_stream_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_stream_tx.sv
// CMOS-style frame-timed video transmitter: pulls pixels from a valid/ready source and emits vsync/href/clken/data.
// Build option CMOS_TX_PATTERN_EN adds pat_sel, selecting an internal coordinate test pattern per frame.
module cmos_stream_tx #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 10,
  parameter int V_FRONT   = 10,
  parameter int DW        = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
`ifdef CMOS_TX_PATTERN_EN
  input  logic          pat_sel,
`endif
  output logic          pix_ready,
  output logic          cmos_vsync,
  output logic          cmos_href,
  output logic          cmos_clken,
  output logic [DW-1:0] cmos_data,
  output logic [15:0]   x_pos,
  output logic [15:0]   y_pos,
  output logic          frame_done,
  output logic          underflow,
  output logic [2:0]    dbg_state
);

  localparam int          H_TOTAL = IMG_HDISP + H_BLANK;
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_ACT   = 16'(IMG_HDISP);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] BACK   = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] FRONT  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [15:0] h_cnt, line_cnt, state_lines;
  logic        line_end, state_end, active_cyc, use_pat;

  assign dbg_state = state;

  always_comb begin
    case (state)
      SYNC:    state_lines = 16'(V_SYNC);
      BACK:    state_lines = 16'(V_BACK);
      ACTIVE:  state_lines = 16'(IMG_VDISP);
      FRONT:   state_lines = 16'(V_FRONT);
      default: state_lines = 16'd1;
    endcase
  end

  assign line_end   = (h_cnt == H_LAST);
  assign state_end  = line_end && (line_cnt == state_lines - 16'd1);
  assign active_cyc = (state == ACTIVE) && (h_cnt < H_ACT);

  // Transitions happen only on the last cycle of a state's final line, so frames are never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)    state_nxt = SYNC;
      SYNC:    if (state_end) state_nxt = BACK;
      BACK:    if (state_end) state_nxt = ACTIVE;
      ACTIVE:  if (state_end) state_nxt = FRONT;
      FRONT:   if (state_end) state_nxt = enable ? SYNC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      h_cnt    <= 16'd0;
      line_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        h_cnt    <= 16'd0;
        line_cnt <= 16'd0;
      end else begin
        h_cnt <= line_end ? 16'd0 : h_cnt + 16'd1;
        if (state_end)     line_cnt <= 16'd0;
        else if (line_end) line_cnt <= line_cnt + 16'd1;
      end
    end
  end

`ifdef CMOS_TX_PATTERN_EN
  logic        pat_q;
  logic [23:0] pat_px;

  // Pattern choice is latched on frame entry so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  pat_q <= 1'b0;
    else if (state_nxt == SYNC && state != SYNC) pat_q <= pat_sel;
  end

  assign use_pat = pat_q;
  assign pat_px  = {h_cnt[7:0], line_cnt[7:0], h_cnt[7:0] ^ line_cnt[7:0]};
`else
  assign use_pat = 1'b0;
`endif

  // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready. pix_ready depends only
  // on timing state (never on pix_valid); if valid is low in a ready cycle the slot goes out as 0.
  assign pix_ready = active_cyc && !use_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_vsync <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_clken <= 1'b0;
      cmos_data  <= '0;
      x_pos      <= 16'd0;
      y_pos      <= 16'd0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      cmos_vsync <= (state == SYNC);
      cmos_href  <= active_cyc;
      cmos_clken <= active_cyc;
      x_pos      <= active_cyc ? h_cnt : 16'd0;
      y_pos      <= active_cyc ? line_cnt : 16'd0;
      frame_done <= (state == FRONT) && state_end;
      if (active_cyc && !use_pat && !pix_valid) underflow <= 1'b1;
      if (!active_cyc)         cmos_data <= '0;
`ifdef CMOS_TX_PATTERN_EN
      else if (use_pat)        cmos_data <= DW'(pat_px);
`endif
      else if (pix_valid)      cmos_data <= pix_data;
      else                     cmos_data <= '0;
    end
  end

endmodule

// File: tb/tb_cmos_stream_tx.sv
// Directed bench for cmos_stream_tx on an 8x4 frame (line 12 cycles, frame 84 cycles).
// Define CMOS_TX_PATTERN_EN on both RTL and bench to include the test-pattern scenario.
module tb_cmos_stream_tx;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
`ifdef CMOS_TX_PATTERN_EN
  logic          pat_sel = 1'b0;
`endif
  logic          pix_ready, cmos_vsync, cmos_href, cmos_clken, frame_done, underflow;
  logic [DW-1:0] cmos_data;
  logic [15:0]   x_pos, y_pos;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  cmos_stream_tx #(
    .IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
`ifdef CMOS_TX_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .pix_ready(pix_ready), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_clken(cmos_clken),
    .cmos_data(cmos_data), .x_pos(x_pos), .y_pos(y_pos), .frame_done(frame_done),
    .underflow(underflow), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int pcnt  = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  // scoreboard and monitor state
  logic [DW-1:0] exp_q[$];
  int            vs_rise_q[$], vs_fall_q[$], done_q[$], href_q[$];
  int            clken_cnt = 0, pix_idx = 0, bad_cnt = 0;
  bit            chk_data = 1'b1;
  logic          vs_d = 1'b0, hr_d = 1'b0;
  logic [DW-1:0] px_5_2 = '0;

  // driver state
  int   src = 0, rdy_idx = 0, drop_at = 0;
  bit   hs_prev = 1'b0, drop_en = 1'b0;
  int   en_t = 0, rel_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmos_vsync && !vs_d) begin
      vs_rise_q.push_back(pcnt);
      pix_idx = 0;
    end
    if (!cmos_vsync && vs_d) vs_fall_q.push_back(pcnt);
    if (cmos_href && !hr_d) href_q.push_back(pcnt);
    if (frame_done) done_q.push_back(pcnt);
    if (cmos_href !== cmos_clken) bad_cnt++;
    if (cmos_clken) begin
      clken_cnt++;
      if (chk_data) begin
        check("exp_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data", 32'(cmos_data), 32'(exp_q.pop_front()));
        check("x_pos", 32'(x_pos), pix_idx % 8);
        check("y_pos", 32'(y_pos), pix_idx / 8);
      end
      if (x_pos == 16'd5 && y_pos == 16'd2) px_5_2 = cmos_data;
      pix_idx++;
    end else if (cmos_data != '0 || x_pos != 16'd0 || y_pos != 16'd0) begin
      bad_cnt++;
    end
    vs_d = cmos_vsync;
    hr_d = cmos_href;
  end

  // One pixel-clock step: the source advances after each accepted pixel; optionally withholds one pixel.
  task automatic cycle();
    @(negedge clk);
    if (hs_prev) src++;
    pix_data  = DW'(src);
    pix_valid = !(drop_en && pix_ready && rdy_idx == drop_at);
    hs_prev   = pix_valid && pix_ready;
    if (pix_ready) rdy_idx++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_mon();
    exp_q.delete();
    vs_rise_q.delete();
    vs_fall_q.delete();
    done_q.delete();
    href_q.delete();
    clken_cnt = 0;
    rdy_idx   = 0;
    src       = 0;
    hs_prev   = 1'b0;
    pix_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_vsync", cmos_vsync, 0);
    check("rst_href", cmos_href, 0);
    check("rst_clken", cmos_clken, 0);
    check("rst_data", 32'(cmos_data), 0);
    check("rst_xy", {x_pos, y_pos}, 0);
    check("rst_flags", {frame_done, underflow, pix_ready}, 0);
    check("rst_state", dbg_state, 0);

    // continuous frames with a steady source, then enable drops mid frame 3
    clear_mon();
    for (int i = 0; i < 96; i++) exp_q.push_back(DW'(i));
    pix_valid = 1'b1;
    rst_n = 1'b1;
    run(3);
    check("idle_no_vsync", vs_rise_q.size(), 0);
    enable = 1'b1;
    en_t = pcnt;
    for (int i = 0; i < 400 && vs_rise_q.size() < 3; i++) cycle();
    check("f3_start", vs_rise_q.size(), 3);
    run(39);
    enable = 1'b0;
    run(100);
    check("vs_lat", vs_rise_q[0] - en_t, 2);
    check("vs_width", vs_fall_q[0] - vs_rise_q[0], 12);
    check("frame_len", vs_rise_q[1] - vs_rise_q[0], 84);
    check("done_pos", done_q[0] - vs_rise_q[0], 83);
    check("done_gap", vs_rise_q[1] - done_q[0], 1);
    check("done_period", done_q[1] - done_q[0], 84);
    check("href_pos", href_q[0] - vs_rise_q[0], 24);
    check("href_space", href_q[1] - href_q[0], 12);
    check("f3_done", done_q[2] - vs_rise_q[2], 83);
    check("n_frames", vs_rise_q.size(), 3);
    check("n_done", done_q.size(), 3);
    check("clken_total", clken_cnt, 96);
    check("ready_total", rdy_idx, 96);
    check("exp_left", exp_q.size(), 0);
    check("underflow_clean", underflow, 0);
    check("idle_outs", {cmos_vsync, cmos_href, cmos_clken, frame_done, pix_ready}, 0);
    check("idle_data", 32'(cmos_data), 0);
    check("idle_state", dbg_state, 0);

    // one pixel withheld at line 1, x=3
    do_reset();
    for (int i = 0; i < 11; i++) exp_q.push_back(DW'(i));
    exp_q.push_back('0);
    for (int i = 11; i < 31; i++) exp_q.push_back(DW'(i));
    drop_en = 1'b1;
    drop_at = 11;
    enable  = 1'b1;
    for (int i = 0; i < 200 && rdy_idx < 11; i++) cycle();
    check("uf_before", underflow, 0);
    enable = 1'b0;
    for (int i = 0; i < 200 && done_q.size() < 1; i++) cycle();
    run(5);
    check("uf_after", underflow, 1);
    check("uf_clken", clken_cnt, 32);
    check("uf_ready", rdy_idx, 32);
    check("uf_exp_left", exp_q.size(), 0);
    check("uf_one_frame", vs_rise_q.size(), 1);
    drop_en = 1'b0;

    // asynchronous reset in the middle of an active line
    do_reset();
    chk_data = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < 200 && !cmos_href; i++) cycle();
    check("href_seen", cmos_href, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_sync_href", {cmos_vsync, cmos_href, cmos_clken}, 0);
    check("async_data", 32'(cmos_data), 0);
    check("async_xy", {x_pos, y_pos}, 0);
    check("async_ready", pix_ready, 0);
    repeat (2) @(negedge clk);
    clear_mon();
    for (int i = 0; i < 32; i++) exp_q.push_back(DW'(i));
    chk_data = 1'b1;
    rst_n = 1'b1;
    rel_t = pcnt;
    for (int i = 0; i < 200 && vs_rise_q.size() < 1; i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 200 && done_q.size() < 1; i++) cycle();
    run(3);
    check("rst_vs_lat", vs_rise_q[0] - rel_t, 2);
    check("rst_frame", done_q[0] - vs_rise_q[0], 83);
    check("rst_clken", clken_cnt, 32);
    check("rst_exp_left", exp_q.size(), 0);

`ifdef CMOS_TX_PATTERN_EN
    // internal test pattern
    do_reset();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        exp_q.push_back({xb, yb, xb ^ yb});
      end
    end
    pat_sel = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 200 && vs_rise_q.size() < 1; i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 200 && done_q.size() < 1; i++) cycle();
    run(3);
    check("pat_px_5_2", 32'(px_5_2), 32'h050207);
    check("pat_ready", rdy_idx, 0);
    check("pat_clken", clken_cnt, 32);
    check("pat_exp_left", exp_q.size(), 0);
    check("pat_underflow", underflow, 0);
    pat_sel = 1'b0;
`endif

    check("outside_zero", bad_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
